// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display with per-slot blanking.
// Optional decimal-point support is enabled by defining SEG_DP_EN.
module seven_seg_scanner #(
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an3char,
    input  logic [3:0] an2char,
    input  logic [3:0] an1char,
    input  logic [3:0] an0char,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_start
`ifdef SEG_DP_EN
   ,input  logic [3:0] dp_in,
    output logic       dp
`endif
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(SLOT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_digit;
    logic [3:0]       r_char [4];
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_frame_start;

    logic             w_load;
    logic             w_last;
    logic             w_blank;
    logic [3:0]       w_char;
    logic [6:0]       w_glyph;
    logic [3:0]       w_an;

    assign w_load = (r_cnt == '0) && (r_digit == 2'd0);
    assign w_last = (r_cnt == LastCnt);
    assign w_an   = ~(4'b1000 >> r_digit);

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CNT_W-1:0] BlankCnt = CNT_W'(BLANK_CYCLES);
            assign w_blank = (r_cnt < BlankCnt);
        end
    endgenerate

    // In the load cycle the shadow still holds the old frame, so take the incoming character.
    assign w_char = w_load ? an3char : r_char[r_digit];

    always_comb begin
        w_glyph = 7'b1111111;
        unique case (w_char)
            4'h0: w_glyph = 7'b1000000;
            4'h1: w_glyph = 7'b1111001;
            4'h2: w_glyph = 7'b0100100;
            4'h3: w_glyph = 7'b0110000;
            4'h4: w_glyph = 7'b0011001;
            4'h5: w_glyph = 7'b0010010;
            4'h6: w_glyph = 7'b0000010;
            4'h7: w_glyph = 7'b1111000;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0010000;
            4'hA: w_glyph = 7'b0001000;
            4'hB: w_glyph = 7'b0000011;
            4'hC: w_glyph = 7'b1000110;
            4'hD: w_glyph = 7'b0100001;
            4'hE: w_glyph = 7'b0000110;
            4'hF: w_glyph = 7'b0001110;
            default: w_glyph = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_digit       <= 2'd0;
            r_char[0]     <= 4'h0;
            r_char[1]     <= 4'h0;
            r_char[2]     <= 4'h0;
            r_char[3]     <= 4'h0;
            r_an          <= 4'b1111;
            r_seg         <= 7'b1111111;
            r_frame_start <= 1'b0;
        end else begin
            if (w_last) begin
                r_cnt   <= '0;
                r_digit <= r_digit + 2'd1;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_load) begin
                r_char[0] <= an3char;
                r_char[1] <= an2char;
                r_char[2] <= an1char;
                r_char[3] <= an0char;
            end
            r_frame_start <= w_load;
            if (w_blank) begin
                r_an  <= 4'b1111;
                r_seg <= 7'b1111111;
            end else begin
                r_an  <= w_an;
                r_seg <= w_glyph;
            end
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign frame_start = r_frame_start;

`ifdef SEG_DP_EN
    logic [3:0] r_dp_sh;
    logic       r_dp;
    logic       w_dp_bit;

    // dp_in bit 3 is the leftmost digit, i.e. digit 0, hence the inverted index.
    assign w_dp_bit = w_load ? dp_in[3] : r_dp_sh[~r_digit];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dp_sh <= 4'h0;
            r_dp    <= 1'b1;
        end else begin
            if (w_load) begin
                r_dp_sh <= dp_in;
            end
            r_dp <= w_blank ? 1'b1 : ~w_dp_bit;
        end
    end

    assign dp = r_dp;
`endif

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a blanked instance (BLANK=2) and an unblanked one (BLANK=0)
// share all inputs; decimal-point checks are active when SEG_DP_EN is defined.
module tb_seven_seg_scanner;

    localparam int unsigned Slot  = 8;
    localparam int unsigned Blank = 2;
    localparam int unsigned Frame = 4 * Slot;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ch [4];
    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       fs_a, fs_b;
`ifdef SEG_DP_EN
    logic [3:0] dp_in;
    logic       dp_a, dp_b;
    logic [3:0] exp_dp;
`endif

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [3:0] exp_sh [4];

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .SLOT_CYCLES (Slot),
        .BLANK_CYCLES(Blank),
        .CNT_W       (4)
    ) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .an3char    (ch[0]),
        .an2char    (ch[1]),
        .an1char    (ch[2]),
        .an0char    (ch[3]),
        .an         (an_a),
        .seg        (seg_a),
        .frame_start(fs_a)
`ifdef SEG_DP_EN
       ,.dp_in      (dp_in),
        .dp         (dp_a)
`endif
    );

    seven_seg_scanner #(
        .SLOT_CYCLES (Slot),
        .BLANK_CYCLES(0),
        .CNT_W       (4)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .an3char    (ch[0]),
        .an2char    (ch[1]),
        .an1char    (ch[2]),
        .an0char    (ch[3]),
        .an         (an_b),
        .seg        (seg_b),
        .frame_start(fs_b)
`ifdef SEG_DP_EN
       ,.dp_in      (dp_in),
        .dp         (dp_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_an_a", 32'(an_a), 32'hF);
        check("rst_seg_a", 32'(seg_a), 32'h7F);
        check("rst_fs_a", 32'(fs_a), 32'h0);
        check("rst_an_b", 32'(an_b), 32'hF);
        check("rst_seg_b", 32'(seg_b), 32'h7F);
        check("rst_fs_b", 32'(fs_b), 32'h0);
`ifdef SEG_DP_EN
        check("rst_dp_a", 32'(dp_a), 32'h1);
`endif
    endtask

    // k is the cycle index within the frame, 0 being the frame_start cycle.
    task automatic check_cycle(input int k);
        int         slot;
        int         c;
        logic [3:0] an_on;
        slot  = (k / Slot) % 4;
        c     = k % Slot;
        an_on = ~(4'b1000 >> slot);
        if (k == 0) begin
            for (int i = 0; i < 4; i++) exp_sh[i] = ch[i];
`ifdef SEG_DP_EN
            exp_dp = dp_in;
`endif
        end
        check("fs_a", 32'(fs_a), 32'(k == 0));
        check("fs_b", 32'(fs_b), 32'(k == 0));
        if (c < Blank) begin
            check("blank_an_a", 32'(an_a), 32'hF);
            check("blank_seg_a", 32'(seg_a), 32'h7F);
        end else begin
            check("an_a", 32'(an_a), 32'(an_on));
            check("seg_a", 32'(seg_a), 32'(glyph_tbl[exp_sh[slot]]));
        end
        check("an_b", 32'(an_b), 32'(an_on));
        check("seg_b", 32'(seg_b), 32'(glyph_tbl[exp_sh[slot]]));
`ifdef SEG_DP_EN
        check("dp_a", 32'(dp_a), (c < Blank) ? 32'h1 : 32'(~exp_dp[3 - slot]));
        check("dp_b", 32'(dp_b), 32'(~exp_dp[3 - slot]));
`endif
    endtask

    initial begin
        reset = 1'b0;
        ch[0] = 4'h1;
        ch[1] = 4'h2;
        ch[2] = 4'h3;
        ch[3] = 4'h4;
`ifdef SEG_DP_EN
        dp_in  = 4'b0100;
        exp_dp = 4'h0;
`endif
        for (int i = 0; i < 4; i++) exp_sh[i] = 4'h0;

        // Held in reset: everything dark.
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_outputs();
        end
        reset = 1'b1;

        // Frame 0 shows 1,2,3,4; mid-frame edits must wait for frame 1.
        // Frames 2..17 sweep an0char through all sixteen glyphs.
        for (int f = 0; f < 18; f++) begin
            for (int k = 0; k < int'(Frame); k++) begin
                step();
                check_cycle(k);
                if (f == 0 && k == 8) ch[2] = 4'h7;
                if (f == 0 && k == 16) ch[0] = 4'hF;
                if (f >= 1 && f <= 16 && k == int'(Frame) - 1) ch[3] = 4'(f - 1);
            end
        end

        // Reset mid-frame while an=1011 is lit, then the frame restarts from blanking.
        for (int k = 0; k < 12; k++) begin
            step();
            check_cycle(k);
        end
        reset = 1'b0;
        step();
        check_reset_outputs();
        reset = 1'b1;
        for (int k = 0; k < int'(Frame); k++) begin
            step();
            check_cycle(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
